// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial CLA adder: state encoding and slice width.
package cla_nibble_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    // 2'd3 is unused; the sequencer treats it as a fault and returns to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index NIB nibbles; never zero so the index register always exists.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_sequencer_cla4_slice.sv
// 4-bit combinational carry look-ahead slice with generate/propagate carries.
module cla4_slice
    import cla_nibble_sequencer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of ci, g and p: no ripple through c[i].
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[NIBBLE_W-1:0];
    assign co = c[NIBBLE_W];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit CLA slice, one nibble per clock, LSB first.
// Define CLA_SEQ_SUB_EN to add the 'sub' port (a - b, cout=1 meaning no borrow).
module cla_nibble_sequencer
    import cla_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE (and low during rst), out_valid only in DONE, and the
    // result on sum/cout holds steady until out_ready completes the transfer.

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic             sub_mode;

`ifdef CLA_SEQ_SUB_EN
    logic sub_reg;
    assign sub_mode = sub_reg;
`else
    assign sub_mode = 1'b0;
`endif

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx == IDX_W'(n)) begin
                a_nib = a_reg[n*NIBBLE_W +: NIBBLE_W];
                b_nib = b_reg[n*NIBBLE_W +: NIBBLE_W];
            end
        end
        slice_b = sub_mode ? ~b_nib : b_nib;
    end

    cla4_slice u_slice (
        .a  (a_nib),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
`ifdef CLA_SEQ_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef CLA_SEQ_SUB_EN
                        sub_reg <= sub;
                        // Two's complement subtract: ~b plus an initial carry of one.
                        carry   <= sub ? 1'b1 : cin;
`else
                        carry   <= cin;
`endif
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (idx == IDX_W'(n)) begin
                            sum[n*NIBBLE_W +: NIBBLE_W] <= slice_s;
                        end
                    end
                    carry <= slice_co;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        cout      <= slice_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    idx       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
